// File: rtl/oam_dma_master_if.sv
// -----------------------------------------------------------------------------
// oam_dma_master_if
//   Memory-bus bundle between the OAM DMA initiator and the 6502-side bus
//   (arbiter plus ROM/RAM responders).
//
//   bus_req   initiator -> arbiter    request for bus ownership
//   bus_gnt   arbiter   -> initiator  grant; initiator drives the bus only while high
//   addr      initiator -> bus        16-bit address, 16'h0000 when not driving
//   oe_n      initiator -> bus        read strobe, active low
//   we_n      initiator -> bus        write strobe, active low
//   data_in   responder -> initiator  read data
//   data_out  initiator -> bus        write data, valid while data_oe=1
//   data_oe   initiator -> top level  enables the tristate data driver
// -----------------------------------------------------------------------------
interface oam_dma_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr;
  logic        oe_n;
  logic        we_n;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;

  modport master (
    output bus_req, addr, oe_n, we_n, data_out, data_oe,
    input  bus_gnt, data_in
  );

  modport slave (
    input  bus_req, addr, oe_n, we_n, data_out, data_oe,
    output bus_gnt, data_in
  );
endinterface

// File: rtl/oam_dma_master.sv
// -----------------------------------------------------------------------------
// oam_dma_master
//   Sprite (OAM) DMA bus initiator. On a start pulse it takes the bus from the
//   arbiter and copies BYTES bytes from source page {page,8'h00} to the fixed
//   port DEST_ADDR. Each byte is read for READ_WAIT+1 cycles (data sampled in
//   the last one) and then written in a single cycle.
//
//   clk    in   system clock, all state changes on posedge
//   reset  in   synchronous active-high reset
//   start  in   one-cycle request pulse, honoured only when idle
//   page   in   source page, latched when start is accepted
//   bus    master modport of oam_dma_master_if (request/grant, address,
//          strobes, read and write data)
//   busy   out  high in every state except IDLE
//   done   out  one-cycle pulse when the transfer completes
// -----------------------------------------------------------------------------
module oam_dma_master #(
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int          READ_WAIT = 1,     // 0..7
  parameter int          BYTES     = 256    // 1..256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              page,
  oam_dma_master_if.master        bus,
  output logic                    busy,
  output logic                    done
);

  localparam logic [8:0] LAST_CNT  = 9'(BYTES - 1);
  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [7:0]  idx_q,   idx_d;
  logic [8:0]  cnt_q,   cnt_d;
  logic [2:0]  wait_q,  wait_d;
  logic [7:0]  byte_q,  byte_d;

  // Output values built here and forwarded to the interface below.
  logic        bus_req_d;
  logic [15:0] addr_d;
  logic        oe_n_d;
  logic        we_n_d;
  logic [7:0]  data_out_d;
  logic        data_oe_d;
  logic        done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      cnt_q   <= 9'd0;
      wait_q  <= 3'd0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    byte_d     = byte_q;

    bus_req_d  = 1'b0;
    addr_d     = 16'h0000;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    data_out_d = 8'h00;
    data_oe_d  = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start is ignored everywhere else, so page is latched only here.
        if (start) begin
          page_d  = page;
          idx_d   = 8'h00;
          cnt_d   = 9'd0;
          wait_d  = 3'd0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        bus_req_d = 1'b1;
        if (bus.bus_gnt) begin
          wait_d  = 3'd0;
          state_d = S_RD;
        end
      end

      S_RD: begin
        bus_req_d = 1'b1;
        // Without grant the bus is left undriven and the byte is retried
        // from the start of its read phase.
        if (bus.bus_gnt) begin
          addr_d = {page_q, idx_q};
          oe_n_d = 1'b0;
          if (wait_q == WAIT_LAST) begin
            byte_d  = bus.data_in;
            state_d = S_WR;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end else begin
          wait_d  = 3'd0;
          state_d = S_REQ;
        end
      end

      S_WR: begin
        bus_req_d = 1'b1;
        // A write cycle only commits (advances idx/cnt) when granted; a lost
        // grant sends the same byte back through REQ and RD.
        if (bus.bus_gnt) begin
          addr_d     = DEST_ADDR;
          data_out_d = byte_q;
          data_oe_d  = 1'b1;
          we_n_d     = 1'b0;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 9'd1;
            idx_d   = idx_q + 8'd1;   // wraps within the page, page_q never moves
            wait_d  = 3'd0;
            state_d = S_RD;
          end
        end else begin
          wait_d  = 3'd0;
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.bus_req  = bus_req_d;
  assign bus.addr     = addr_d;
  assign bus.oe_n     = oe_n_d;
  assign bus.we_n     = we_n_d;
  assign bus.data_out = data_out_d;
  assign bus.data_oe  = data_oe_d;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_d;

endmodule

// File: tb/tb_oam_dma_master.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_master
//   Drives oam_dma_master with a behavioural ROM/RAM responder and arbiter.
//   Every expected (source address, data) pair of a transfer is queued when
//   the transfer is started; a negedge monitor checks each read address and
//   each committed write against the head of that queue.
// -----------------------------------------------------------------------------
module tb_oam_dma_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] page;
  logic       busy;
  logic       done;

  oam_dma_master_if bus ();

  oam_dma_master #(
    .DEST_ADDR (16'h2004),
    .READ_WAIT (1),
    .BYTES     (256)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .page  (page),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Source memory contents: a fixed, address-dependent byte pattern.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return 8'(a[7:0] * 8'd7) ^ a[15:8] ^ 8'hA5;
  endfunction

  assign bus.data_in = (bus.oe_n == 1'b0) ? mem_val(bus.addr) : 8'h00;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t       sb_q[$];
  int         checks      = 0;
  int         failures    = 0;
  int         cyc         = 0;
  int         writes_seen = 0;
  int         done_cnt    = 0;
  int         done_cyc    = 0;
  bit         mon_en      = 1'b0;
  bit         off_page    = 1'b0;
  logic [7:0] cur_page    = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!bus.oe_n && !bus.we_n) begin
        failures++;
        $display("FAIL strobe_overlap: oe_n=%b we_n=%b, required never both low", bus.oe_n, bus.we_n);
      end
      checks++;
      if (bus.data_oe && bus.we_n) begin
        failures++;
        $display("FAIL data_oe_no_write: data_oe=%b we_n=%b, required data_oe only with we_n=0", bus.data_oe, bus.we_n);
      end
      if (!bus.oe_n) begin
        checks++;
        if (bus.addr[15:8] !== cur_page) off_page = 1'b1;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL read_unexpected: addr=%h read with no byte pending", bus.addr);
        end else if (bus.addr !== sb_q[0].addr) begin
          failures++;
          $display("FAIL read_addr: got %h required %h", bus.addr, sb_q[0].addr);
        end
      end
      if (!bus.we_n && bus.bus_gnt) begin
        checks++;
        writes_seen++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected: addr=%h data=%h with no byte pending", bus.addr, bus.data_out);
        end else begin
          if (bus.addr !== 16'h2004 || bus.data_out !== sb_q[0].data) begin
            failures++;
            $display("FAIL write: got addr=%h data=%h required addr=2004 data=%h (src %h)",
                     bus.addr, bus.data_out, sb_q[0].data, sb_q[0].addr);
          end
          void'(sb_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (bus.bus_req !== 1'b0) begin
          failures++;
          $display("FAIL done_bus_req: bus_req=%b during done, required 0", bus.bus_req);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [7:0] p);
    logic [15:0] a;
    for (int i = 0; i < 256; i++) begin
      a = {p, 8'(i)};
      sb_q.push_back('{addr: a, data: mem_val(a)});
    end
    cur_page = p;
    off_page = 1'b0;
  endtask

  // Drives a one-cycle start pulse; c0 is the cycle in which start is high.
  task automatic pulse_start(input logic [7:0] p, output int c0);
    page  = p;
    start = 1'b1;
    c0    = cyc;
    tick();
    start = 1'b0;
    page  = 8'h33;  // page must have been latched already
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    start       = 1'b0;
    page        = 8'h00;
    bus.bus_gnt = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.bus_req !== 1'b0 || bus.addr !== 16'h0000 || bus.oe_n !== 1'b1 || bus.we_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_bus: req=%b addr=%h oe_n=%b we_n=%b required 0 0000 1 1",
               bus.bus_req, bus.addr, bus.oe_n, bus.we_n);
    end
    checks++;
    if (bus.data_out !== 8'h00 || bus.data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: data_out=%h data_oe=%b busy=%b done=%b required 00 0 0 0",
               bus.data_out, bus.data_oe, busy, done);
    end
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_full_copy();
    int c0, wb;
    bit ok;
    bus.bus_gnt = 1'b1;
    push_block(8'h02);
    wb = writes_seen;
    pulse_start(8'h02, c0);
    checks++;
    if (busy !== 1'b1 || bus.bus_req !== 1'b1) begin
      failures++;
      $display("FAIL full_req_cycle1: busy=%b bus_req=%b required 1 1", busy, bus.bus_req);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_done_timeout: no done within 2000 cycles");
    end
    checks++;
    if (done_cyc - c0 != 770) begin
      failures++;
      $display("FAIL full_done_cycle: got %0d required 770", done_cyc - c0);
    end
    checks++;
    if (writes_seen - wb != 256 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL full_write_count: got %0d writes, %0d pending, required 256, 0",
               writes_seen - wb, sb_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_busy_after: busy=%b required 0", busy);
    end
    $display("test_full_copy: page 02, %0d writes, done at cycle %0d", writes_seen - wb, done_cyc - c0);
  endtask

  task automatic test_grant_delay();
    int c0, wb;
    bit ok;
    bus.bus_gnt = 1'b0;
    push_block(8'h03);
    wb = writes_seen;
    pulse_start(8'h03, c0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.bus_req !== 1'b1 || bus.oe_n !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL gnt_wait_req: cycle %0d req=%b oe_n=%b busy=%b required 1 1 1",
                 i, bus.bus_req, bus.oe_n, busy);
      end
      tick();
    end
    bus.bus_gnt = 1'b1;
    tick();
    checks++;
    if (bus.oe_n !== 1'b0 || bus.addr !== 16'h0300) begin
      failures++;
      $display("FAIL gnt_first_read: oe_n=%b addr=%h required 0 0300", bus.oe_n, bus.addr);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok || writes_seen - wb != 256 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL gnt_delay_complete: done=%b writes=%0d pending=%0d required 1 256 0",
               ok, writes_seen - wb, sb_q.size());
    end
    $display("test_grant_delay: page 03, %0d writes after late grant", writes_seen - wb);
  endtask

  task automatic test_grant_loss();
    int c0, wb;
    bit ok, found;
    bus.bus_gnt = 1'b1;
    push_block(8'h04);
    wb = writes_seen;
    pulse_start(8'h04, c0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.oe_n && bus.addr == 16'h0405) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL loss_find_rd5: read of 0405 not seen within 100 cycles");
    end
    bus.bus_gnt = 1'b0;
    tick();
    checks++;
    if (bus.bus_req !== 1'b1 || bus.oe_n !== 1'b1 || bus.we_n !== 1'b1) begin
      failures++;
      $display("FAIL loss_to_req: req=%b oe_n=%b we_n=%b required 1 1 1", bus.bus_req, bus.oe_n, bus.we_n);
    end
    repeat (2) tick();
    bus.bus_gnt = 1'b1;
    tick();
    checks++;
    if (bus.oe_n !== 1'b0 || bus.addr !== 16'h0405) begin
      failures++;
      $display("FAIL loss_reread: oe_n=%b addr=%h required 0 0405", bus.oe_n, bus.addr);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok || writes_seen - wb != 256 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL loss_complete: done=%b writes=%0d pending=%0d required 1 256 0",
               ok, writes_seen - wb, sb_q.size());
    end
    $display("test_grant_loss: page 04, byte 5 retried, %0d writes", writes_seen - wb);
  endtask

  task automatic test_reset_mid();
    int c0, wb, d0;
    bit found;
    bus.bus_gnt = 1'b1;
    push_block(8'h05);
    wb = writes_seen;
    pulse_start(8'h05, c0);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (writes_seen - wb == 100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_reach: byte 100 not reached within 1000 cycles");
    end
    d0    = done_cnt;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.bus_req !== 1'b0 || bus.addr !== 16'h0000 || bus.oe_n !== 1'b1 || bus.we_n !== 1'b1 ||
        bus.data_out !== 8'h00 || bus.data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle: req=%b addr=%h oe_n=%b we_n=%b dout=%h doe=%b busy=%b done=%b required all idle",
               bus.bus_req, bus.addr, bus.oe_n, bus.we_n, bus.data_out, bus.data_oe, busy, done);
    end
    reset = 1'b0;
    sb_q.delete();
    repeat (30) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_no_done: done pulses=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
    $display("test_reset_mid: page 05 aborted after %0d writes", writes_seen - wb);
  endtask

  task automatic test_start_while_busy();
    int c0, c1, d0;
    bit ok;
    bus.bus_gnt = 1'b1;
    push_block(8'h02);
    d0 = done_cnt;
    pulse_start(8'h02, c0);
    repeat (50) tick();
    pulse_start(8'h07, c1);
    wait_done(2000, ok);
    repeat (20) tick();
    checks++;
    if (off_page || sb_q.size() != 0) begin
      failures++;
      $display("FAIL busy_start_page: off_page=%b pending=%0d required 0 0", off_page, sb_q.size());
    end
    checks++;
    if (!ok || done_cnt - d0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_done: done pulses=%0d busy=%b required 1 0", done_cnt - d0, busy);
    end
    $display("test_start_while_busy: second start ignored, %0d done pulse(s)", done_cnt - d0);
  endtask

  task automatic test_page_ff();
    int c0, wb;
    bit ok;
    bus.bus_gnt = 1'b1;
    push_block(8'hFF);
    wb = writes_seen;
    pulse_start(8'hFF, c0);
    wait_done(2000, ok);
    tick();
    checks++;
    if (!ok || done_cyc - c0 != 770) begin
      failures++;
      $display("FAIL ff_done: done=%b cycle=%0d required 1 770", ok, done_cyc - c0);
    end
    checks++;
    if (off_page || writes_seen - wb != 256 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL ff_no_wrap: off_page=%b writes=%0d pending=%0d required 0 256 0",
               off_page, writes_seen - wb, sb_q.size());
    end
    $display("test_page_ff: FF00..FFFF copied, %0d writes", writes_seen - wb);
  endtask

  initial begin
    test_reset();
    test_full_copy();
    test_grant_delay();
    test_grant_loss();
    test_reset_mid();
    test_start_while_busy();
    test_page_ff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
